// File: rtl/decode_stage_if.sv
// Fetch/regfile/execute signal bundle for the RV32I decode stage.
// slave is the decode side, master is whoever drives fetch, the register file and execute.
interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) ();
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_inst;
  logic [XLEN-1:0]  if_pc;
  logic [RF_AW-1:0] rf_rs1_addr;
  logic [RF_AW-1:0] rf_rs2_addr;
  logic [XLEN-1:0]  rf_rs1_data;
  logic [XLEN-1:0]  rf_rs2_data;
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  logic [XLEN-1:0]  ex_op1;
  logic [XLEN-1:0]  ex_op2;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_pc;
  logic [2:0]       ex_funct3;
  logic [6:0]       ex_funct7;
  logic [6:0]       ex_opcode;
  logic [RF_AW-1:0] ex_rd;
  logic             ex_reg_wen;
  logic             ex_illegal;

  modport slave (
    input  if_valid, if_inst, if_pc, rf_rs1_data, rf_rs2_data, flush, ex_ready,
    output if_ready, rf_rs1_addr, rf_rs2_addr, ex_valid, ex_op1, ex_op2, ex_rs2_data,
           ex_imm, ex_pc, ex_funct3, ex_funct7, ex_opcode, ex_rd, ex_reg_wen, ex_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, rf_rs1_data, rf_rs2_data, flush, ex_ready,
    input  if_ready, rf_rs1_addr, rf_rs2_addr, ex_valid, ex_op1, ex_op2, ex_rs2_data,
           ex_imm, ex_pc, ex_funct3, ex_funct7, ex_opcode, ex_rd, ex_reg_wen, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word plus register-file
// operands, captured into a single output register handed to execute over valid/ready.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] inst);
    return {{(XLEN-12){inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] inst);
    return {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] inst);
    return {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] inst);
    return {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] inst);
    return {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // ---- stage p0: combinational decode of the fetched word ----
  logic [6:0]              opcode_p0;
  logic [2:0]              inst_f3_p0;
  logic [RF_AW-1:0]        rd_p0;
  logic signed [XLEN-1:0]  rs1_p0, rs2_p0;
  logic signed [XLEN-1:0]  op1_p0, op2_p0, imm_p0;
  logic [2:0]              funct3_p0;
  logic [6:0]              funct7_p0;
  logic                    wen_p0, illegal_p0;
  logic                    accept_p0;

  // ---- stage p1: bundle register presented to execute ----
  logic                    vld_p1;
  logic signed [XLEN-1:0]  op1_p1, op2_p1, rs2_p1, imm_p1;
  logic [XLEN-1:0]         pc_p1;
  logic [2:0]              funct3_p1;
  logic [6:0]              funct7_p1, opcode_p1;
  logic [RF_AW-1:0]        rd_p1;
  logic                    wen_p1, illegal_p1;

  assign opcode_p0   = bus.if_inst[6:0];
  assign inst_f3_p0  = bus.if_inst[14:12];
  assign rd_p0       = bus.if_inst[11:7];
  assign rs1_p0      = $signed(bus.rf_rs1_data);
  assign rs2_p0      = $signed(bus.rf_rs2_data);

  assign bus.rf_rs1_addr = bus.if_inst[19:15];
  assign bus.rf_rs2_addr = bus.if_inst[24:20];

  assign bus.if_ready = ~bus.flush & (~vld_p1 | bus.ex_ready);
  assign accept_p0    = bus.if_valid & bus.if_ready;

  // Opcode decode: select ALU operands, immediate, ALU function fields and write enable.
  always_comb begin
    op1_p0     = '0;
    op2_p0     = '0;
    imm_p0     = '0;
    funct3_p0  = 3'b000;
    funct7_p0  = 7'b0;
    wen_p0     = 1'b0;
    illegal_p0 = 1'b0;
    if (bus.if_inst[1:0] != 2'b11) begin
      illegal_p0 = 1'b1;
    end else begin
      case (opcode_p0)
        OPC_OP: begin
          op1_p0    = rs1_p0;
          op2_p0    = rs2_p0;
          wen_p0    = 1'b1;
          funct3_p0 = inst_f3_p0;
          funct7_p0 = bus.if_inst[31:25];
        end
        OPC_OPIMM: begin
          op1_p0    = rs1_p0;
          imm_p0    = imm_i(bus.if_inst);
          op2_p0    = imm_i(bus.if_inst);
          wen_p0    = 1'b1;
          funct3_p0 = inst_f3_p0;
          // Shifts: funct7 carries the arithmetic/logical selector, so op2 is only the shamt.
          if (inst_f3_p0 == 3'b001 || inst_f3_p0 == 3'b101) begin
            funct7_p0 = bus.if_inst[31:25];
            op2_p0    = $signed({{(XLEN-5){1'b0}}, bus.if_inst[24:20]});
          end
        end
        OPC_LOAD, OPC_JALR: begin
          op1_p0 = rs1_p0;
          imm_p0 = imm_i(bus.if_inst);
          op2_p0 = imm_i(bus.if_inst);
          wen_p0 = 1'b1;
        end
        OPC_STORE: begin
          op1_p0 = rs1_p0;
          imm_p0 = imm_s(bus.if_inst);
          op2_p0 = imm_s(bus.if_inst);
        end
        OPC_BRANCH: begin
          op1_p0    = rs1_p0;
          op2_p0    = rs2_p0;
          imm_p0    = imm_b(bus.if_inst);
          funct3_p0 = inst_f3_p0;
        end
        OPC_LUI: begin
          imm_p0 = imm_u(bus.if_inst);
          op2_p0 = imm_u(bus.if_inst);
          wen_p0 = 1'b1;
        end
        OPC_AUIPC: begin
          op1_p0 = $signed(bus.if_pc);
          imm_p0 = imm_u(bus.if_inst);
          op2_p0 = imm_u(bus.if_inst);
          wen_p0 = 1'b1;
        end
        OPC_JAL: begin
          op1_p0 = $signed(bus.if_pc);
          imm_p0 = imm_j(bus.if_inst);
          op2_p0 = imm_j(bus.if_inst);
          wen_p0 = 1'b1;
        end
        default: illegal_p0 = 1'b1;
      endcase
    end
    if (rd_p0 == '0) wen_p0 = 1'b0;
  end

  // Output register: load on accept, drop on flush or consumption, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      op1_p1     <= '0;
      op2_p1     <= '0;
      rs2_p1     <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      funct3_p1  <= '0;
      funct7_p1  <= '0;
      opcode_p1  <= '0;
      rd_p1      <= '0;
      wen_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      op1_p1     <= op1_p0;
      op2_p1     <= op2_p0;
      rs2_p1     <= rs2_p0;
      imm_p1     <= imm_p0;
      pc_p1      <= bus.if_pc;
      funct3_p1  <= funct3_p0;
      funct7_p1  <= funct7_p0;
      opcode_p1  <= opcode_p0;
      rd_p1      <= rd_p0;
      wen_p1     <= wen_p0;
      illegal_p1 <= illegal_p0;
    end else if (vld_p1 && bus.ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.ex_valid    = vld_p1;
  assign bus.ex_op1      = op1_p1;
  assign bus.ex_op2      = op2_p1;
  assign bus.ex_rs2_data = rs2_p1;
  assign bus.ex_imm      = imm_p1;
  assign bus.ex_pc       = pc_p1;
  assign bus.ex_funct3   = funct3_p1;
  assign bus.ex_funct7   = funct7_p1;
  assign bus.ex_opcode   = opcode_p1;
  assign bus.ex_rd       = rd_p1;
  assign bus.ex_reg_wen  = wen_p1;
  assign bus.ex_illegal  = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes the hand-decoded bundle when an
// instruction is accepted; the monitor pops and compares on every execute handshake.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  exp_t sb[$];

  decode_stage_if #(.XLEN(32), .RF_AW(5)) bus ();

  decode_stage #(.XLEN(32), .RF_AW(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model: x0=0, x1=10, x2=0x80000000, others = index<<8.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    case (a)
      5'd0:    return 32'h0;
      5'd1:    return 32'd10;
      5'd2:    return 32'h8000_0000;
      default: return {19'b0, a, 8'b0};
    endcase
  endfunction

  assign bus.rf_rs1_data = rf_val(bus.rf_rs1_addr);
  assign bus.rf_rs2_data = rf_val(bus.rf_rs2_addr);

  function automatic exp_t mk(input logic [31:0] op1, op2, rs2, imm, pc,
                              input logic [2:0] f3, input logic [6:0] f7, opc,
                              input logic [4:0] rd, input logic wen, ill);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.rs2 = rs2; e.imm = imm; e.pc = pc;
    e.f3 = f3; e.f7 = f7; e.opc = opc; e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t cur();
    return mk(bus.ex_op1, bus.ex_op2, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc,
              bus.ex_funct3, bus.ex_funct7, bus.ex_opcode, bus.ex_rd,
              bus.ex_reg_wen, bus.ex_illegal);
  endfunction

  task automatic show_fail(input string name, input exp_t a, input exp_t r);
    failures++;
    $display("FAIL %s actual op1=%h op2=%h rs2=%h imm=%h pc=%h f3=%h f7=%h opc=%h rd=%0d wen=%b ill=%b required op1=%h op2=%h rs2=%h imm=%h pc=%h f3=%h f7=%h opc=%h rd=%0d wen=%b ill=%b",
             name, a.op1, a.op2, a.rs2, a.imm, a.pc, a.f3, a.f7, a.opc, a.rd, a.wen, a.ill,
             r.op1, r.op2, r.rs2, r.imm, r.pc, r.f3, r.f7, r.opc, r.rd, r.wen, r.ill);
  endtask

  task automatic check_bit(input string name, input logic a, input logic r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, a, r);
    end
  endtask

  // Monitor: every execute handshake must match the oldest outstanding bundle.
  always @(negedge clock) begin
    if (reset_n && bus.ex_valid && bus.ex_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bundle actual pc=%h required none", bus.ex_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cur() !== e) show_fail("bundle", cur(), e);
      end
    end
  end

  // Present one instruction, wait (bounded) for acceptance, then record the expectation.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    int n;
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    n = 0;
    @(negedge clock);
    while (!bus.if_ready && n < 20) begin
      n++;
      @(negedge clock);
    end
    if (!bus.if_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual if_ready=0 required 1 pc=%h", pc);
    end else begin
      sb.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clock);
    #1;
    bus.if_valid = 1'b0;
  endtask

  exp_t e_sub, e_add, e_addi2;
  int   b_cyc;

  initial begin
    reset_n      = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'h0;
    bus.if_pc    = 32'h0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || cur() !== '0) show_fail("reset_state", cur(), '0);
    reset_n = 1'b1;

    // Back-to-back stream of every opcode class plus illegal encodings.
    send(32'hFFF08293, 32'h00, mk(32'd10, 32'hFFFFFFFF, 32'h1F00, 32'hFFFFFFFF, 32'h00, 3'd0, 7'h00, 7'h13, 5'd5, 1'b1, 1'b0));
    send(32'h40415193, 32'h04, mk(32'h80000000, 32'd4, 32'h400, 32'h404, 32'h04, 3'd5, 7'h20, 7'h13, 5'd3, 1'b1, 1'b0));
    send(32'h0020A423, 32'h08, mk(32'd10, 32'd8, 32'h80000000, 32'd8, 32'h08, 3'd0, 7'h00, 7'h23, 5'd8, 1'b0, 1'b0));
    send(32'h402081B3, 32'h0C, mk(32'd10, 32'h80000000, 32'h80000000, 32'h0, 32'h0C, 3'd0, 7'h20, 7'h33, 5'd3, 1'b1, 1'b0));
    send(32'hFE209EE3, 32'h10, mk(32'd10, 32'h80000000, 32'h80000000, 32'hFFFFFFFC, 32'h10, 3'd1, 7'h00, 7'h63, 5'd29, 1'b0, 1'b0));
    send(32'hFF80A203, 32'h14, mk(32'd10, 32'hFFFFFFF8, 32'h1800, 32'hFFFFFFF8, 32'h14, 3'd0, 7'h00, 7'h03, 5'd4, 1'b1, 1'b0));
    send(32'h000280E7, 32'h18, mk(32'h500, 32'h0, 32'h0, 32'h0, 32'h18, 3'd0, 7'h00, 7'h67, 5'd1, 1'b1, 1'b0));
    send(32'h00001397, 32'h200, mk(32'h200, 32'h1000, 32'h0, 32'h1000, 32'h200, 3'd0, 7'h00, 7'h17, 5'd7, 1'b1, 1'b0));
    send(32'h008000EF, 32'h100, mk(32'h100, 32'd8, 32'h800, 32'd8, 32'h100, 3'd0, 7'h00, 7'h6F, 5'd1, 1'b1, 1'b0));
    send(32'h12345037, 32'h1C, mk(32'h0, 32'h12345000, 32'h300, 32'h12345000, 32'h1C, 3'd0, 7'h00, 7'h37, 5'd0, 1'b0, 1'b0));
    send(32'h00000000, 32'h20, mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h20, 3'd0, 7'h00, 7'h00, 5'd0, 1'b0, 1'b1));
    send(32'h00000FFF, 32'h24, mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h24, 3'd0, 7'h00, 7'h7F, 5'd31, 1'b0, 1'b1));
    send(32'h00000012, 32'h28, mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h28, 3'd0, 7'h00, 7'h12, 5'd0, 1'b0, 1'b1));
    @(posedge clock);
    #1;

    // Backpressure: bundle held stable and input blocked for 3 cycles.
    e_sub   = mk(32'd10, 32'h80000000, 32'h80000000, 32'h0, 32'h40, 3'd0, 7'h20, 7'h33, 5'd3, 1'b1, 1'b0);
    e_add   = mk(32'd10, 32'h80000000, 32'h80000000, 32'h0, 32'h44, 3'd0, 7'h00, 7'h33, 5'd3, 1'b1, 1'b0);
    e_addi2 = mk(32'd10, 32'hFFFFFFFF, 32'h1F00, 32'hFFFFFFFF, 32'h48, 3'd0, 7'h00, 7'h13, 5'd5, 1'b1, 1'b0);
    bus.ex_ready = 1'b0;
    send(32'h402081B3, 32'h40, e_sub);
    bus.if_valid = 1'b1;
    bus.if_inst  = 32'h002081B3;
    bus.if_pc    = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_bit("bp_if_ready", bus.if_ready, 1'b0);
      checks++;
      if (bus.ex_valid !== 1'b1 || cur() !== e_sub) show_fail("bp_stable", cur(), e_sub);
      @(posedge clock);
      #1;
    end
    bus.ex_ready = 1'b1;
    send(32'h002081B3, 32'h44, e_add);
    b_cyc = acc_cyc;
    send(32'hFFF08293, 32'h48, e_addi2);
    checks++;
    if (acc_cyc != b_cyc + 1) begin
      failures++;
      $display("FAIL back_to_back actual gap=%0d required 1", acc_cyc - b_cyc);
    end
    @(posedge clock);
    #1;

    // Flush while holding a stalled bundle.
    bus.ex_ready = 1'b0;
    send(32'h0020A423, 32'h50, mk(32'd10, 32'd8, 32'h80000000, 32'd8, 32'h50, 3'd0, 7'h00, 7'h23, 5'd8, 1'b0, 1'b0));
    bus.flush    = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_inst  = 32'h008000EF;
    bus.if_pc    = 32'h54;
    @(negedge clock);
    check_bit("flush_if_ready", bus.if_ready, 1'b0);
    @(posedge clock);
    #1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    check_bit("flush_ex_valid", bus.ex_valid, 1'b0);
    void'(sb.pop_back());
    bus.ex_ready = 1'b1;

    // Asynchronous reset while a bundle is stalled.
    bus.ex_ready = 1'b0;
    send(32'hFF80A203, 32'h60, mk(32'd10, 32'hFFFFFFF8, 32'h1800, 32'hFFFFFFF8, 32'h60, 3'd0, 7'h00, 7'h03, 5'd4, 1'b1, 1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || cur() !== '0) show_fail("reset_mid_bundle", cur(), '0);
    void'(sb.pop_back());
    @(posedge clock);
    #1;
    reset_n      = 1'b1;
    bus.ex_ready = 1'b1;

    // Normal operation resumes after reset.
    send(32'hFFF08293, 32'h70, mk(32'd10, 32'hFFFFFFFF, 32'h1F00, 32'hFFFFFFFF, 32'h70, 3'd0, 7'h00, 7'h13, 5'd5, 1'b1, 1'b0));
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual outstanding=%0d required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
